blit_engine: RTL and testbench

//  Parametrised rectangle blitter for the 2D graphics core. Accepts one command per

---
 rtl/blit_pkg.sv | 23 ++
 rtl/blit_addr_gen.sv | 67 ++++++
 rtl/blit_engine.sv | 152 +++++++++++++++
 tb/tb_blit_engine.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/blit_pkg.sv
// Shared encodings and default widths for the rectangle blitter.
package blit_pkg;

   localparam int unsigned BLIT_PIX_W     = 8;
   localparam int unsigned BLIT_ADDR_W    = 16;
   localparam int unsigned BLIT_DIM_W     = 8;
   localparam int unsigned BLIT_FB_STRIDE = 320;

   localparam logic [1:0] BLIT_COPY       = 2'd0;
   localparam logic [1:0] BLIT_COPY_KEYED = 2'd1;
   localparam logic [1:0] BLIT_FILL       = 2'd2;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RD   = 2'd1;
   localparam logic [1:0] S_WR   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // Mode 3 is reserved and behaves as FILL, so bit 1 alone selects fill.
   function automatic logic is_fill(input logic [1:0] mode);
      return mode[1];
   endfunction

endpackage

// File: rtl/blit_addr_gen.sv
// Raster walker: x/y counters plus running source and framebuffer addresses, incrementers only.
module blit_addr_gen
   import blit_pkg::*;
#(
   parameter int unsigned ADDR_W    = BLIT_ADDR_W,
   parameter int unsigned DIM_W     = BLIT_DIM_W,
   parameter int unsigned FB_STRIDE = BLIT_FB_STRIDE
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              step,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] dst_base,
   input  logic [DIM_W-1:0]  w,
   input  logic [DIM_W-1:0]  h,
   output logic [ADDR_W-1:0] src_addr,
   output logic [ADDR_W-1:0] dst_addr,
   output logic              last_pix
);

   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(FB_STRIDE);

   logic [DIM_W-1:0]  x_q;
   logic [DIM_W-1:0]  y_q;
   logic [DIM_W-1:0]  w_q;
   logic [DIM_W-1:0]  h_q;
   logic [ADDR_W-1:0] row_q;
   logic              last_col;

   // Row carry and last-pixel are decoded from the same counter state.
   assign last_col = (x_q == (w_q - DIM_W'(1)));
   assign last_pix = last_col && (y_q == (h_q - DIM_W'(1)));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         x_q      <= '0;
         y_q      <= '0;
         w_q      <= '0;
         h_q      <= '0;
         row_q    <= '0;
         src_addr <= '0;
         dst_addr <= '0;
      end else if (start) begin
         x_q      <= '0;
         y_q      <= '0;
         w_q      <= w;
         h_q      <= h;
         row_q    <= dst_base;
         src_addr <= src_base;
         dst_addr <= dst_base;
      end else if (step && !last_pix) begin
         // Source rows are packed, so the source pointer simply counts up.
         src_addr <= src_addr + ADDR_W'(1);
         if (last_col) begin
            x_q      <= '0;
            y_q      <= y_q + DIM_W'(1);
            row_q    <= row_q + STRIDE;
            dst_addr <= row_q + STRIDE;
         end else begin
            x_q      <= x_q + DIM_W'(1);
            dst_addr <= dst_addr + ADDR_W'(1);
         end
      end
   end

endmodule

// File: rtl/blit_engine.sv
// Single-command rectangle blitter: copy, colour-keyed copy or solid fill into the framebuffer.
module blit_engine
   import blit_pkg::*;
#(
   parameter int unsigned PIX_W     = BLIT_PIX_W,
   parameter int unsigned ADDR_W    = BLIT_ADDR_W,
   parameter int unsigned DIM_W     = BLIT_DIM_W,
   parameter int unsigned FB_STRIDE = BLIT_FB_STRIDE
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_mode,
   input  logic [ADDR_W-1:0] cmd_src,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [DIM_W-1:0]  cmd_w,
   input  logic [DIM_W-1:0]  cmd_h,
   input  logic [PIX_W-1:0]  cmd_color,
   input  logic [PIX_W-1:0]  cmd_key,
   output logic              src_rd_en,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [PIX_W-1:0]  src_rd_data,
   output logic              fb_wr_en,
   output logic [ADDR_W-1:0] fb_addr,
   output logic [PIX_W-1:0]  fb_wr_data,
   input  logic              fb_wait,
   output logic              busy,
   output logic              done
);

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [1:0]       mode_q;
   logic [PIX_W-1:0] color_q;
   logic [PIX_W-1:0] key_q;
   logic [PIX_W-1:0] hold_q;
   logic             first_q;
   logic             wr_q;
   logic             start;
   logic             step;
   logic             last_pix;
   logic             zero_dim;
   logic             fill_q;
   logic             skip;

   assign zero_dim = (cmd_w == '0) || (cmd_h == '0);
   assign fill_q   = is_fill(mode_q);

   // A keyed pixel is dropped in its first WR cycle, before fb_wait can matter.
   assign skip = (mode_q == BLIT_COPY_KEYED) && first_q && (src_rd_data == key_q);

   // Read data arrives in the first WR cycle; later stall cycles replay the captured copy.
   assign fb_wr_en   = wr_q && !skip;
   assign fb_wr_data = !wr_q   ? '0 :
                       fill_q  ? color_q :
                       first_q ? src_rd_data : hold_q;

   blit_addr_gen #(
      .ADDR_W    (ADDR_W),
      .DIM_W     (DIM_W),
      .FB_STRIDE (FB_STRIDE)
   ) u_addr_gen (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .step     (step),
      .src_base (cmd_src),
      .dst_base (cmd_dst),
      .w        (cmd_w),
      .h        (cmd_h),
      .src_addr (src_addr),
      .dst_addr (fb_addr),
      .last_pix (last_pix)
   );

   // Next-state and step/start strobes.
   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      step    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               start = 1'b1;
               if (zero_dim) begin
                  state_d = S_DONE;
               end else if (is_fill(cmd_mode)) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_RD: begin
            state_d = S_WR;
         end
         S_WR: begin
            if (skip || !fb_wait) begin
               step = 1'b1;
               if (last_pix) begin
                  state_d = S_DONE;
               end else if (fill_q) begin
                  state_d = S_WR;
               end else begin
                  state_d = S_RD;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, command latch and registered status outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         mode_q    <= BLIT_COPY;
         color_q   <= '0;
         key_q     <= '0;
         hold_q    <= '0;
         first_q   <= 1'b0;
         wr_q      <= 1'b0;
         src_rd_en <= 1'b0;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_d;
         first_q   <= (state_q == S_RD);
         wr_q      <= (state_d == S_WR);
         src_rd_en <= (state_d == S_RD);
         cmd_ready <= (state_d == S_IDLE);
         busy      <= (state_d != S_IDLE);
         done      <= (state_d == S_DONE);
         if (first_q) begin
            hold_q <= src_rd_data;
         end
         if (start) begin
            mode_q  <= cmd_mode;
            color_q <= cmd_color;
            key_q   <= cmd_key;
         end
      end
   end

endmodule

// File: tb/tb_blit_engine.sv
// Table-driven bench for blit_engine with a write scoreboard fed from a reference raster model.
module tb_blit_engine;
   import blit_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_mode;
   logic [15:0] cmd_src;
   logic [15:0] cmd_dst;
   logic [7:0]  cmd_w;
   logic [7:0]  cmd_h;
   logic [7:0]  cmd_color;
   logic [7:0]  cmd_key;
   logic        src_rd_en;
   logic [15:0] src_addr;
   logic [7:0]  src_rd_data;
   logic        fb_wr_en;
   logic [15:0] fb_addr;
   logic [7:0]  fb_wr_data;
   logic        fb_wait;
   logic        busy;
   logic        done;

   always #5 clock = ~clock;

   blit_engine #(
      .PIX_W     (8),
      .ADDR_W    (16),
      .DIM_W     (8),
      .FB_STRIDE (320)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_mode    (cmd_mode),
      .cmd_src     (cmd_src),
      .cmd_dst     (cmd_dst),
      .cmd_w       (cmd_w),
      .cmd_h       (cmd_h),
      .cmd_color   (cmd_color),
      .cmd_key     (cmd_key),
      .src_rd_en   (src_rd_en),
      .src_addr    (src_addr),
      .src_rd_data (src_rd_data),
      .fb_wr_en    (fb_wr_en),
      .fb_addr     (fb_addr),
      .fb_wr_data  (fb_wr_data),
      .fb_wait     (fb_wait),
      .busy        (busy),
      .done        (done)
   );

   // Synchronous sprite RAM model.
   logic [7:0] src_mem [0:65535];
   always @(posedge clock) begin
      if (src_rd_en) src_rd_data <= src_mem[src_addr];
   end

   typedef struct {
      logic [1:0]  mode;
      logic [15:0] src;
      logic [15:0] dst;
      logic [7:0]  w;
      logic [7:0]  h;
      logic [7:0]  color;
      logic [7:0]  key;
      int          stall;
      int          exp_done;
   } vec_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   wr_t  exp_q[$];
   vec_t vecs[9];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic run_cmd(input vec_t v, input int abort_at);
      int   cyc, nwr, nrd, done_cyc, stall_left, held, n_exp, exp_rd;
      logic stable_ok;
      logic keyed, fill;
      logic [7:0] p;
      wr_t  hw, got;
      cyc = 0; nwr = 0; nrd = 0; done_cyc = -1; held = 0;
      stall_left = v.stall;
      stable_ok  = 1'b1;
      keyed = (v.mode == BLIT_COPY_KEYED);
      fill  = v.mode[1];
      exp_q.delete();
      for (int y = 0; y < int'(v.h); y++) begin
         for (int x = 0; x < int'(v.w); x++) begin
            p = fill ? v.color : src_mem[16'(int'(v.src) + y * int'(v.w) + x)];
            if (!(keyed && p == v.key))
               exp_q.push_back('{addr: 16'(int'(v.dst) + y * 320 + x), data: p});
         end
      end
      n_exp  = exp_q.size();
      exp_rd = (fill || v.w == 0 || v.h == 0) ? 0 : int'(v.w) * int'(v.h);

      @(negedge clock);
      chk("ready_before_cmd", 64'(cmd_ready), 64'(1));
      cmd_valid = 1'b1; cmd_mode = v.mode; cmd_src = v.src; cmd_dst = v.dst;
      cmd_w = v.w; cmd_h = v.h; cmd_color = v.color; cmd_key = v.key;
      @(posedge clock);
      #1 cmd_valid = 1'b0;

      while (done_cyc < 0 && cyc < 3000) begin
         @(negedge clock);
         cyc++;
         if (fb_wr_en && stall_left > 0) begin
            fb_wait = 1'b1;
            stall_left--;
         end else begin
            fb_wait = 1'b0;
         end
         if (src_rd_en) nrd++;
         if (fb_wr_en && fb_wait) begin
            if (held == 0) hw = '{addr: fb_addr, data: fb_wr_data};
            else if (hw != {fb_addr, fb_wr_data}) stable_ok = 1'b0;
            held++;
         end
         if (fb_wr_en && !fb_wait) begin
            if (held > 0 && nwr == 0 && hw != {fb_addr, fb_wr_data}) stable_ok = 1'b0;
            if (exp_q.size() > 0) begin
               got = exp_q.pop_front();
               chk($sformatf("wr%0d_addr", nwr), 64'(fb_addr), 64'(got.addr));
               chk($sformatf("wr%0d_data", nwr), 64'(fb_wr_data), 64'(got.data));
            end
            nwr++;
         end
         if (done) done_cyc = cyc;
         if (abort_at >= 0 && nwr == abort_at) break;
      end
      fb_wait = 1'b0;
      if (abort_at >= 0) begin
         chk("abort_point_reached", 64'(nwr), 64'(abort_at));
         return;
      end
      chk("done_cycle", 64'(done_cyc), 64'(v.exp_done));
      chk("write_count", 64'(nwr), 64'(n_exp));
      chk("read_count", 64'(nrd), 64'(exp_rd));
      if (v.stall > 0) chk("stall_hold_stable", 64'(stable_ok), 64'(1));
      @(negedge clock);
      chk("after_done_busy_ready_done", 64'({busy, cmd_ready, done}), 64'(3'b010));
   endtask

   initial begin
      vec_t r;
      for (int i = 0; i < 65536; i++) src_mem[i] = 8'(i * 7 + 3);
      src_mem[16'h0200] = 8'h00; src_mem[16'h0201] = 8'h7F; src_mem[16'h0202] = 8'h00;
      src_mem[16'h0300] = 8'h11; src_mem[16'h0301] = 8'h22; src_mem[16'h0302] = 8'h11;
      src_mem[16'h0303] = 8'h33; src_mem[16'h0304] = 8'h44; src_mem[16'h0305] = 8'h11;

      //           mode             src       dst       w  h  color  key    stall done
      vecs[0] = '{BLIT_COPY,       16'h0100, 16'h0000, 2, 2, 8'h00, 8'h00, 0,  9};
      vecs[1] = '{BLIT_FILL,       16'h0000, 16'h0010, 3, 1, 8'hA5, 8'h00, 0,  4};
      vecs[2] = '{BLIT_COPY_KEYED, 16'h0200, 16'h0500, 3, 1, 8'h00, 8'h00, 0,  7};
      vecs[3] = '{BLIT_COPY,       16'h0100, 16'h0040, 2, 2, 8'h00, 8'h00, 3, 12};
      vecs[4] = '{BLIT_COPY,       16'h0100, 16'h0080, 0, 5, 8'h00, 8'h00, 0,  1};
      vecs[5] = '{2'd3,            16'h1234, 16'hFFFE, 4, 3, 8'h3C, 8'h00, 0, 13};
      vecs[6] = '{BLIT_COPY_KEYED, 16'h0300, 16'h1000, 3, 2, 8'h00, 8'h11, 0, 13};
      vecs[7] = '{BLIT_FILL,       16'h0000, 16'h0200, 3, 0, 8'h77, 8'h00, 0,  1};
      vecs[8] = '{BLIT_COPY,       16'hFFFF, 16'h2000, 2, 1, 8'h00, 8'h00, 0,  5};

      reset = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_src = '0; cmd_dst = '0;
      cmd_w = '0; cmd_h = '0; cmd_color = '0; cmd_key = '0; fb_wait = 1'b0;
      repeat (2) @(negedge clock);
      chk("reset_ready", 64'(cmd_ready), 64'(1));
      chk("reset_flags", 64'({busy, done, src_rd_en, fb_wr_en}), 64'(0));
      chk("reset_addr_data", 64'({src_addr, fb_addr, fb_wr_data}), 64'(0));
      reset = 1'b1;

      for (int i = 0; i < 9; i++) run_cmd(vecs[i], -1);

      // Abort a 4x4 copy after its fifth write has been presented.
      r = '{BLIT_COPY, 16'h0400, 16'h3000, 4, 4, 8'h00, 8'h00, 0, 33};
      run_cmd(r, 5);
      reset = 1'b0;
      #1;
      chk("abort_flags", 64'({fb_wr_en, src_rd_en, busy, done}), 64'(0));
      chk("abort_addrs", 64'({fb_addr, src_addr}), 64'(0));
      chk("abort_data", 64'(fb_wr_data), 64'(0));
      repeat (2) begin
         @(negedge clock);
         chk("abort_no_write", 64'(fb_wr_en), 64'(0));
      end
      reset = 1'b1;
      @(negedge clock);
      chk("ready_after_reset", 64'(cmd_ready), 64'(1));
      run_cmd(vecs[0], -1);
      run_cmd(vecs[6], -1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
